// File: rtl/rx_stream_arbiter.sv
// Merges two lvds_rx sample streams into one FIFO write port through per-channel
// elastic buffers and a round-robin arbiter; overflowing words are counted as drops.
module rx_stream_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_ddr_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_ch_enable,
  input  logic             i_clear_cnt,
  input  logic             i_ch0_push,
  input  logic [31:0]      i_ch0_data,
  input  logic             i_ch1_push,
  input  logic [31:0]      i_ch1_data,
  input  logic             i_fifo_full,
  output logic             o_fifo_push,
  output logic [31:0]      o_fifo_data,
  output logic             o_fifo_ch,
  output logic [1:0]       o_ch_full,
  output logic [CNT_W-1:0] o_drop_cnt0,
  output logic [CNT_W-1:0] o_drop_cnt1
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [1:0]       push_in;
  logic [31:0]      data_in  [2];
  logic [31:0]      head     [2];
  logic [CNT_W-1:0] drop_cnt [2];
  logic [1:0]       elig;
  logic [1:0]       gnt;
  logic             gnt_any;
  logic             gnt_ch;
  logic             rr_q, rr_d;
  logic             push_q;
  logic [31:0]      data_q;
  logic             ch_q;

  assign push_in    = {i_ch1_push, i_ch0_push};
  assign data_in[0] = i_ch0_data;
  assign data_in[1] = i_ch1_data;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             is_full;
    logic             wr_en;
    logic             drop;

    assign is_full = (occ_q == FULL_OCC);
    // A full buffer still accepts when it is popped in the same cycle.
    assign wr_en   = push_in[gi] && i_ch_enable[gi] && (!is_full || gnt[gi]);
    assign drop    = push_in[gi] && i_ch_enable[gi] && is_full && !gnt[gi];

    assign elig[gi]      = i_ch_enable[gi] && (occ_q != '0);
    assign head[gi]      = mem[rd_ptr_q];
    assign o_ch_full[gi] = is_full;
    assign drop_cnt[gi]  = drop_q;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      drop_d   = drop_q;
      if (!i_ch_enable[gi]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        occ_d    = '0;
      end else begin
        if (wr_en)   wr_ptr_d = wr_ptr_q + AW'(1);
        if (gnt[gi]) rd_ptr_d = rd_ptr_q + AW'(1);
        occ_d = occ_q + (AW+1)'(wr_en) - (AW+1)'(gnt[gi]);
      end
      if (i_clear_cnt)                 drop_d = '0;
      else if (drop && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
    end

    always_ff @(posedge i_ddr_clk) begin
      if (i_reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        occ_q    <= '0;
        drop_q   <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        occ_q    <= occ_d;
        drop_q   <= drop_d;
      end
    end

    always_ff @(posedge i_ddr_clk) begin
      if (wr_en) mem[wr_ptr_q] <= data_in[gi];
    end
  end

  always_comb begin
    gnt_any = !i_fifo_full && (elig != 2'b00);
    gnt_ch  = (elig == 2'b11) ? rr_q : elig[1];
    gnt     = 2'b00;
    rr_d    = rr_q;
    if (gnt_any) begin
      gnt    = gnt_ch ? 2'b10 : 2'b01;
      rr_d   = ~gnt_ch;
    end
  end

  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      rr_q   <= 1'b0;
      push_q <= 1'b0;
      data_q <= '0;
      ch_q   <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      push_q <= gnt_any;
      if (gnt_any) begin
        data_q <= head[gnt_ch];
        ch_q   <= gnt_ch;
      end
    end
  end

  assign o_fifo_push = push_q;
  assign o_fifo_data = data_q;
  assign o_fifo_ch   = ch_q;
  assign o_drop_cnt0 = drop_cnt[0];
  assign o_drop_cnt1 = drop_cnt[1];

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Randomized and directed bench for rx_stream_arbiter against a queue-based reference model.
module tb_rx_stream_arbiter;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [1:0]       en;
  logic             clr;
  logic             p0, p1;
  logic [31:0]      d0, d1;
  logic             full;
  logic             o_fifo_push;
  logic [31:0]      o_fifo_data;
  logic             o_fifo_ch;
  logic [1:0]       o_ch_full;
  logic [CNT_W-1:0] o_drop_cnt0;
  logic [CNT_W-1:0] o_drop_cnt1;

  rx_stream_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_ddr_clk   (clk),
    .i_reset     (rst),
    .i_ch_enable (en),
    .i_clear_cnt (clr),
    .i_ch0_push  (p0),
    .i_ch0_data  (d0),
    .i_ch1_push  (p1),
    .i_ch1_data  (d1),
    .i_fifo_full (full),
    .o_fifo_push (o_fifo_push),
    .o_fifo_data (o_fifo_data),
    .o_fifo_ch   (o_fifo_ch),
    .o_ch_full   (o_ch_full),
    .o_drop_cnt0 (o_drop_cnt0),
    .o_drop_cnt1 (o_drop_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_out0 = 0;
  int n_out1 = 0;
  int base;

  // Reference model state: plain word queues, preferred channel, drop totals.
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  int          m_rr = 0;
  int          m_drop0 = 0;
  int          m_drop1 = 0;
  logic        m_push = 1'b0;
  logic [31:0] m_data = '0;
  logic        m_ch = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit e0, e1;
    int g;
    if (rst) begin
      mq0.delete(); mq1.delete();
      m_rr = 0; m_drop0 = 0; m_drop1 = 0;
      m_push = 1'b0; m_data = '0; m_ch = 1'b0;
      return;
    end
    e0 = en[0] && (mq0.size() > 0);
    e1 = en[1] && (mq1.size() > 0);
    g = -1;
    if (!full && (e0 || e1)) g = (e0 && e1) ? m_rr : (e0 ? 0 : 1);
    m_push = (g >= 0);
    if (g == 0) begin m_data = mq0.pop_front(); m_ch = 1'b0; m_rr = 1; end
    if (g == 1) begin m_data = mq1.pop_front(); m_ch = 1'b1; m_rr = 0; end
    if (!en[0]) mq0.delete();
    else if (p0) begin
      if (mq0.size() < DEPTH) mq0.push_back(d0);
      else if (m_drop0 < CMAX) m_drop0++;
    end
    if (!en[1]) mq1.delete();
    else if (p1) begin
      if (mq1.size() < DEPTH) mq1.push_back(d1);
      else if (m_drop1 < CMAX) m_drop1++;
    end
    if (clr) begin m_drop0 = 0; m_drop1 = 0; end
  endtask

  task automatic compare();
    check_eq("push", o_fifo_push, m_push);
    check_eq("data", o_fifo_data, m_data);
    check_eq("ch", o_fifo_ch, m_ch);
    check_eq("full0", o_ch_full[0], mq0.size() == DEPTH);
    check_eq("full1", o_ch_full[1], mq1.size() == DEPTH);
    check_eq("drop0", o_drop_cnt0, m_drop0);
    check_eq("drop1", o_drop_cnt1, m_drop1);
    if (o_fifo_push) begin
      if (o_fifo_ch) n_out1++;
      else           n_out0++;
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge,
  // then the one-cycle strobes are released.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    p0 = 1'b0; p1 = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 2'b11; clr = 1'b0; full = 1'b0;
    p0 = 1'b0; p1 = 1'b0; d0 = '0; d1 = '0;
    do_reset();
    check_eq("rst_push", o_fifo_push, 0);
    check_eq("rst_data", o_fifo_data, 0);
    check_eq("rst_chfull", o_ch_full, 0);

    // Single channel, one push every 16 cycles.
    en = 2'b01;
    base = n_out0;
    for (int i = 0; i < 8; i++) begin
      p0 = 1'b1; d0 = $urandom;
      tick();
      for (int k = 0; k < 15; k++) tick();
    end
    check_eq("single_count", n_out0 - base, 8);

    // Contention from reset: ch0 first, then with rr=1 ch1 first.
    do_reset();
    en = 2'b11;
    p0 = 1'b1; d0 = 32'hA000_0000; p1 = 1'b1; d1 = 32'hB000_0000;
    tick();
    tick();
    check_eq("arb0_ch", o_fifo_ch, 0);
    check_eq("arb0_data", o_fifo_data, 32'hA000_0000);
    tick();
    check_eq("arb1_ch", o_fifo_ch, 1);
    check_eq("arb1_data", o_fifo_data, 32'hB000_0000);
    p0 = 1'b1; d0 = 32'hA000_0001;
    tick();
    tick();
    p0 = 1'b1; d0 = 32'hA000_0002; p1 = 1'b1; d1 = 32'hB000_0002;
    tick();
    tick();
    check_eq("arb_rr1_ch", o_fifo_ch, 1);
    check_eq("arb_rr1_data", o_fifo_data, 32'hB000_0002);
    tick();
    check_eq("arb_rr1_next", o_fifo_ch, 0);

    // Back-pressure: 6 pushes into a depth-4 buffer, 2 drops, first 4 drain.
    full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p1 = 1'b1; d1 = 32'h100 + i;
      tick();
      if (i == 3) check_eq("bp_full_after4", o_ch_full[1], 1);
    end
    check_eq("bp_drops", o_drop_cnt1, 2);
    full = 1'b0;
    base = n_out1;
    for (int i = 0; i < 6; i++) tick();
    check_eq("bp_drain_count", n_out1 - base, 4);

    // Saturation and clear-wins-over-drop.
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      p0 = 1'b1; d0 = 32'h200 + i;
      tick();
    end
    check_eq("sat_cnt", o_drop_cnt0, 3);
    p0 = 1'b1; d0 = 32'h2FF; clr = 1'b1;
    tick();
    check_eq("clr_cnt", o_drop_cnt0, 0);

    // Disable for one cycle flushes the buffer.
    do_reset();
    en = 2'b11; full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p0 = 1'b1; d0 = 32'h300 + i;
      tick();
    end
    en = 2'b10; p0 = 1'b1; d0 = 32'h3FF;
    tick();
    en = 2'b11; full = 1'b0;
    base = n_out0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("flush_none_out", n_out0 - base, 0);
    check_eq("flush_no_drop", o_drop_cnt0, 0);
    p0 = 1'b1; d0 = 32'h3AA;
    tick();
    tick();
    check_eq("reen_out", n_out0 - base, 1);
    check_eq("reen_data", o_fifo_data, 32'h3AA);

    // Reset mid-stream with both buffers holding words.
    full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      p0 = 1'b1; d0 = 32'h400 + i; p1 = 1'b1; d1 = 32'h500 + i;
      tick();
    end
    rst = 1'b1; p0 = 1'b1; p1 = 1'b1; d0 = 32'h4FF; d1 = 32'h5FF;
    tick();
    check_eq("midrst_push", o_fifo_push, 0);
    check_eq("midrst_data", o_fifo_data, 0);
    check_eq("midrst_chfull", o_ch_full, 0);
    rst = 1'b0; full = 1'b0;
    base = n_out0 + n_out1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("midrst_no_stale", n_out0 + n_out1 - base, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      en[0] = ($urandom_range(0, 39) != 0);
      en[1] = ($urandom_range(0, 39) != 0);
      p0   = ($urandom_range(0, 3) == 0);
      p1   = ($urandom_range(0, 3) == 0);
      d0   = $urandom;
      d1   = $urandom;
      full = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 59) == 0);
      tick();
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_stream_arbiter.md
# rx_stream_arbiter

Merges the two `lvds_rx` sample streams (channel 0: sub-GHz modem, channel 1: 2.4 GHz modem) into the single downstream sample FIFO. It sits between the two `lvds_rx` instances and the FIFO write port. Each channel has a small elastic buffer, and the block arbitrates fairly (round-robin) between them. Each output word carries a channel tag, and words that arrive while a buffer is full are counted as drops.

## Interface
- `DEPTH`, 4: per-channel buffer entries; power of two, ≥2.
- `CNT_W`, 16: width of each drop counter.

- `i_ddr_clk` in 1: clock; both `lvds_rx` instances and the FIFO write side run on it.
- `i_reset` in 1: synchronous, active-high.
- `i_ch_enable` in 2: per-channel enable; bit n gates channel n.
- `i_clear_cnt` in 1: synchronously clears both drop counters.
- `i_ch0_push` in 1: channel 0 word valid (1-cycle strobe).
- `i_ch0_data` in 32: channel 0 I/Q word.
- `i_ch1_push` in 1: channel 1 word valid.
- `i_ch1_data` in 32: channel 1 I/Q word.
- `i_fifo_full` in 1: downstream FIFO full; must assert with ≥1 free entry of margin.
- `o_fifo_push` out 1: write strobe to the FIFO, registered.
- `o_fifo_data` out 32: word to the FIFO, unmodified from input, registered.
- `o_fifo_ch` out 1: channel tag of `o_fifo_data`, registered.
- `o_ch_full` out 2: bit n = buffer n holds `DEPTH` words.
- `o_drop_cnt0` out `CNT_W`: channel 0 dropped-word count, saturating.
- `o_drop_cnt1` out `CNT_W`: channel 1 dropped-word count, saturating.

## Operation
- **Per-channel buffer:** circular, `DEPTH` entries, read/write pointers plus an occupancy count of width log2(`DEPTH`)+1.
- **Write:**
  - Accepted when `push` && `enable` && (occupancy < `DEPTH` || this channel is granted this cycle).
  - A push while the buffer is full and not granted is a drop: the word is discarded and the drop counter increments.
- **Disabled channel:**
  - Pushes are ignored and not counted.
  - The buffer is flushed (pointers and occupancy zeroed) on every cycle enable is low.
  - A word already registered on the output still completes.
- **Arbiter** (2-state round-robin pointer `rr`, the preferred channel; reset value 0):
  - A grant is possible when `i_fifo_full`=0 and at least one enabled buffer is non-empty.
  - If both are eligible, grant `rr`. If only one is eligible, grant it.
  - On a grant, `rr` becomes the other channel.
  - No grant means `rr` holds.
- **Output:** on a grant, the head word is popped. On the next edge, `o_fifo_push`=1, `o_fifo_data`=head, `o_fifo_ch`=channel. With no grant, `o_fifo_push`=0 and data/ch hold their last values.
- **Drop counters:** saturate at 2^`CNT_W`−1. `i_clear_cnt` zeroes both and wins over a same-cycle drop; that dropped word is not counted.
- **Bandwidth:** at most one output word per cycle. Each `lvds_rx` pushes at most once per 16 cycles, so the sustained load is ≤2/16 and drops only occur under FIFO back-pressure.

## Timing
- **Reset values:**
  - `o_fifo_push`=0, `o_fifo_data`=0, `o_fifo_ch`=0, `o_ch_full`=0, both drop counters=0.
  - Buffers empty, `rr`=0.
- **Reset mid-operation:** buffered words are discarded; a push sampled in the reset cycle is ignored.
- **Latency:** a push sampled at edge k into an empty buffer is granted in cycle k→k+1 and appears with `o_fifo_push`=1 after edge k+1 (minimum 1 cycle).
- **Back-pressure:** `i_fifo_full` sampled in cycle c blocks the push that would appear after edge c+1. One push may already be in flight, hence the 1-entry margin requirement.
- **Simultaneous pushes:** both channels pushing into empty buffers in the same cycle are output on consecutive cycles, `rr` channel first.
- **Full and granted:** if a full buffer is granted in the same cycle as its push, the new word is accepted. Occupancy stays `DEPTH`, `o_ch_full` stays 1, and there is no drop.
- **`o_ch_full`:** combinational from the registered occupancy; it reflects state after the previous edge.

## Test plan
- **Single channel:** ch0 enabled, 8 pushes every 16 cycles, `i_fifo_full`=0 → 8 output pushes, each 1 cycle after its input, data identical, `o_fifo_ch`=0, drops 0.
- **Contention/fairness:**
  - Both channels push A0 and B0 in the same cycle after reset → A0 (ch 0) then B0 (ch 1) on consecutive cycles.
  - Repeat with `rr`=1 → B0 first.
- **Back-pressure and drops:** hold `i_fifo_full`=1, push 6 words on ch1 with `DEPTH`=4 → `o_ch_full`[1]=1 after the 4th, `o_drop_cnt1`=2. After full is released, exactly the first 4 words are output, in order.
- **Saturation/clear:** `CNT_W`=2, 5 drops → counter=3. Assert `i_clear_cnt` in the same cycle as another drop → counter=0.
- **Enable/flush:** fill ch0 with 3 words, then deassert `i_ch_enable`[0] for 1 cycle → no ch0 words are output. Pushes while disabled are not counted; a push after re-enable is output normally.
- **Reset mid-stream:** assert `i_reset` with both buffers non-empty → the next cycle shows all outputs at their reset values, and no stale word is ever pushed.
